jk_bank_cmd_arbiter: RTL and testbench
======================================

// Module: jk_bank_cmd_arbiter
// PURPOSE
//  Shares one bank of NBITS external positive-edge JK flip-flops (J,K,clk,Q) between
//  NREQ requesters. Each command is clear, set, toggle or hold on one bit.
//  Round-robin arbiter, then a 3-state sequencer that drives one-hot J/K pulses
//  and checks the bank's Q read-back against JK semantics.
//  Sits between requester logic and the jk instances; Q feeds back on q_in.
// PARAMETERS
//  NREQ   4  number of requesters
//  NBITS  8  number of JK flip-flops in the bank
//  IDXW   3  bit-index width per requester; values >= NBITS are out of range
// PORTS
//  clk      in   1          clock, all state updates on posedge
//  rst      in   1          synchronous reset, active-high
//  req      in   NREQ       request per requester; held high until its gnt
//  op       in   2*NREQ     {J,K} per requester, slice i = op[2i+1:2i]: 00 hold, 01 clear, 10 set, 11 toggle
//  idx      in   IDXW*NREQ  target bit per requester, slice i = idx[IDXW*i +: IDXW]
//  gnt      out  NREQ       one-cycle completion pulse to the winner
//  j_out    out  NBITS      J inputs of the bank
//  k_out    out  NBITS      K inputs of the bank
//  q_in     in   NBITS      Q outputs of the bank
//  busy     out  1          high whenever state != IDLE
//  err      out  1          sticky read-back mismatch flag
//  cmd_cnt  out  8          completed-command counter, wraps 255 -> 0
// BEHAVIOUR
//  Reset: state=IDLE, ptr=0, gnt=0, j_out=0, k_out=0, busy=0, err=0, cmd_cnt=0.
//   rst wins over every other event, including mid-command; the command is dropped
//   and gnt is never sent.
//  Registers: all outputs are registered.
//  FSM: IDLE -> ISSUE -> ACK -> IDLE. Exactly 3 cycles per command, no back-to-back.
//  IDLE:
//   - If req != 0, select the first set bit at or after ptr, circularly (ptr is highest priority).
//   - Latch win, op[win] and idx[win]; go to ISSUE.
//   - If req == 0, stay in IDLE.
//  ISSUE:
//   - For exactly one cycle, j_out[idx]=op[1] and k_out[idx]=op[0]; every other bit is 0.
//   - Sample old = q_in[idx] in this cycle. The bank updates on the edge that ends ISSUE.
//  ACK:
//   - j_out and k_out return to 0; gnt[win]=1 for this cycle only.
//   - exp = old (00), 0 (01), 1 (10), ~old (11). If q_in[idx] != exp, set err=1.
//   - err stays 1 until rst.
//   - cmd_cnt increments by 1; ptr = (win+1) mod NREQ.
//  Out-of-range idx (>= NBITS): still granted and counted. j_out and k_out stay 0.
//   No check is made and err is unchanged.
//  Op 00 (hold) is a legal command: zero pulse, full 3-cycle sequence, and it is checked.
//  req changes during ISSUE or ACK are ignored. Arbitration happens only in IDLE.
//  A requester that drops req before gnt may still be granted its latched command.
//  Outside ISSUE, j_out and k_out are all 0, so the bank holds.
// TESTING
//  1. rst=1 for 2 cycles -> every output 0 and busy=0. Pulse rst during ISSUE ->
//     next cycle IDLE, j_out=0, no gnt.
//  2. Single requester: req=0001, op0=10, idx0=5 ->
//     j_out=0x20 and k_out=0 for 1 cycle; gnt=0001 2 cycles after acceptance;
//     q_in[5]=1; err=0; cmd_cnt=1.
//  3. Toggle: bit 2 at 1, req0 op=11 idx=2 -> j_out=k_out=0x04 for 1 cycle;
//     q_in[2]=0; err=0. Repeat -> q_in[2]=1.
//  4. Fairness: req=1111 held -> grants 0001, 0010, 0100, 1000, 0001, one every 3 cycles.
//     Then req=1010 with ptr=2 -> grant 1000, then 0010.
//  5. Bad bank: q_in tied to 0x00, op=10 idx=0 -> err=1 in the cycle after ACK,
//     and err stays 1 over later good commands.
//  6. Edge cases: idx=7 op=00 -> gnt, no pulse, err=0. idx out of range (NBITS=6, idx=7)
//     -> gnt, j_out=k_out=0. 256 commands -> cmd_cnt wraps to 0.

Source files
------------

// File: rtl/jk_bank_cmd_arbiter.sv
// jk_bank_cmd_arbiter: round-robin shared access to a bank of external JK flip-flops with Q read-back checking
module jk_bank_cmd_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int IDXW  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_i,
  input  logic [2*NREQ-1:0]    op_i,
  input  logic [IDXW*NREQ-1:0] idx_i,
  output logic [NREQ-1:0]      gnt_o,
  output logic [NBITS-1:0]     j_out_o,
  output logic [NBITS-1:0]     k_out_o,
  input  logic [NBITS-1:0]     q_in_i,
  output logic                 busy_o,
  output logic                 err_o,
  output logic [7:0]           cmd_cnt_o
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, win_q, win_d, pick, cand;
  logic found;
  logic [1:0] op_q, op_d, op_in;
  logic [IDXW-1:0] idx_q, idx_d, idx_in;
  logic [NBITS-1:0] sel, sel_in, j_q, j_d, k_q, k_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic old_q, old_d, err_q, err_d, qbit, exp_b;
  logic [7:0] cnt_q, cnt_d;
  // First requester at or after ptr, scanning circularly; the scan runs
  // backwards so the candidate nearest ptr is the one left standing.
  always_comb begin
    pick = '0;
    cand = '0;
    found = 1'b0;
    for (int n = NREQ - 1; n >= 0; n--) begin
      cand = PW'((int'(ptr_q) + n) % NREQ);
      if (req_i[cand]) begin
        pick = cand;
        found = 1'b1;
      end
    end
  end
  assign op_in  = op_i[2*pick +: 2];
  assign idx_in = idx_i[IDXW*pick +: IDXW];
  // An out-of-range index shifts the one bit off the end, giving an empty mask,
  // which suppresses both the pulse and the read-back check.
  assign sel_in = NBITS'(1) << idx_in;
  assign sel    = NBITS'(1) << idx_q;
  assign qbit   = |(q_in_i & sel);
  assign exp_b  = op_q == 2'b00 ? old_q : op_q == 2'b01 ? 1'b0 : op_q == 2'b10 ? 1'b1 : ~old_q;
  // Sequencer: latch winner in IDLE, pulse J/K in ISSUE, grant and verify in ACK.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    op_d    = op_q;
    idx_d   = idx_q;
    j_d     = '0;
    k_d     = '0;
    gnt_d   = '0;
    old_d   = old_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = ISSUE;
        win_d   = pick;
        op_d    = op_in;
        idx_d   = idx_in;
        j_d     = op_in[1] ? sel_in : '0;
        k_d     = op_in[0] ? sel_in : '0;
      end
      ISSUE: begin
        state_d      = ACK;
        old_d        = qbit;
        gnt_d[win_q] = 1'b1;
      end
      ACK: begin
        state_d = IDLE;
        err_d   = err_q | ((|sel) & (qbit != exp_b));
        cnt_d   = cnt_q + 8'd1;
        ptr_d   = win_q == PW'(NREQ - 1) ? '0 : win_q + PW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  // State and registered outputs; reset drops any command in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      op_q    <= '0;
      idx_q   <= '0;
      j_q     <= '0;
      k_q     <= '0;
      gnt_q   <= '0;
      old_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      j_q     <= j_d;
      k_q     <= k_d;
      gnt_q   <= gnt_d;
      old_q   <= old_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  assign gnt_o     = gnt_q;
  assign j_out_o   = j_q;
  assign k_out_o   = k_q;
  assign busy_o    = state_q != IDLE;
  assign err_o     = err_q;
  assign cmd_cnt_o = cnt_q;
endmodule

// File: tb/tb_jk_bank_cmd_arbiter.sv
// tb_jk_bank_cmd_arbiter: directed and random commands against a JK-bank model and arbitration reference
module tb_jk_bank_cmd_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req;
  logic [7:0] op;
  logic [11:0] idx;
  logic [3:0] gnt, s_gnt;
  logic [7:0] j_out, k_out, q_in, cmd_cnt, s_cnt;
  logic [5:0] s_j, s_k;
  logic busy, err, s_busy, s_err;
  logic [7:0] bank;
  logic bad;
  int checks = 0, errors = 0;
  int ptr = 0;
  logic [7:0] m_cnt = 0;
  logic m_err = 0;

  jk_bank_cmd_arbiter #(.NREQ(4), .NBITS(8), .IDXW(3)) dut (
    .clk(clk), .rst(rst), .req_i(req), .op_i(op), .idx_i(idx), .gnt_o(gnt),
    .j_out_o(j_out), .k_out_o(k_out), .q_in_i(q_in), .busy_o(busy), .err_o(err), .cmd_cnt_o(cmd_cnt));

  jk_bank_cmd_arbiter #(.NREQ(4), .NBITS(6), .IDXW(3)) dut_small (
    .clk(clk), .rst(rst), .req_i(req), .op_i(op), .idx_i(idx), .gnt_o(s_gnt),
    .j_out_o(s_j), .k_out_o(s_k), .q_in_i(q_in[5:0]), .busy_o(s_busy), .err_o(s_err), .cmd_cnt_o(s_cnt));

  always #5 clk = ~clk;

  always @(posedge clk) bank <= rst ? 8'h00 : (j_out & ~bank) | (~k_out & bank);

  assign q_in = bad ? 8'h00 : bank;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    ptr = 0;
    m_cnt = 0;
    m_err = 0;
  endtask

  task automatic cmd(input logic [3:0] r, input logic [7:0] o, input logic [11:0] x);
    int w, ci;
    logic [1:0] co;
    logic [7:0] pj, pk;
    logic old, e;
    req = r;
    op = o;
    idx = x;
    w = -1;
    for (int n = 0; n < 4; n++) if (w < 0 && r[(ptr + n) % 4]) w = (ptr + n) % 4;
    co = o[2*w +: 2];
    ci = int'(x[3*w +: 3]);
    pj = co[1] ? 8'(1) << ci : 8'h00;
    pk = co[0] ? 8'(1) << ci : 8'h00;
    @(posedge clk); #1;
    chk("issue_busy", busy, 1);
    chk("issue_j", j_out, pj);
    chk("issue_k", k_out, pk);
    chk("issue_gnt", gnt, 0);
    chk("small_issue_j", s_j, ci < 6 ? pj[5:0] : 6'h00);
    chk("small_issue_k", s_k, ci < 6 ? pk[5:0] : 6'h00);
    old = q_in[ci];
    req = 4'($urandom);
    @(posedge clk); #1;
    e = co == 2'b00 ? old : co == 2'b01 ? 1'b0 : co == 2'b10 ? 1'b1 : ~old;
    if (q_in[ci] !== e) m_err = 1'b1;
    chk("ack_gnt", gnt, 4'(1) << w);
    chk("small_ack_gnt", s_gnt, 4'(1) << w);
    chk("ack_j", j_out, 0);
    chk("ack_k", k_out, 0);
    chk("ack_busy", busy, 1);
    if (!bad) chk("bank_bit", q_in[ci], e);
    m_cnt++;
    ptr = (w + 1) % 4;
    @(posedge clk); #1;
    req = 4'h0;
    chk("idle_busy", busy, 0);
    chk("idle_gnt", gnt, 0);
    chk("cmd_cnt", cmd_cnt, m_cnt);
    chk("small_cnt", s_cnt, m_cnt);
    chk("err", err, m_err);
  endtask

  initial begin
    rst = 1'b1;
    req = 4'h0;
    op = 8'h00;
    idx = 12'h000;
    bad = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_j", j_out, 0);
    chk("rst_k", k_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", cmd_cnt, 0);
    rst = 1'b0;
    model_reset();
    cmd(4'b0001, 8'b10, 12'd5);
    chk("set_bit5", q_in[5], 1);
    cmd(4'b0001, 8'b10, 12'd2);
    cmd(4'b0001, 8'b11, 12'd2);
    chk("toggle_bit2_lo", q_in[2], 0);
    cmd(4'b0001, 8'b11, 12'd2);
    chk("toggle_bit2_hi", q_in[2], 1);
    repeat (6) cmd(4'b1111, 8'($urandom), 12'($urandom));
    cmd(4'b1010, 8'($urandom), 12'($urandom));
    cmd(4'b1010, 8'($urandom), 12'($urandom));
    req = 4'b0001;
    op = 8'b10;
    idx = 12'd5;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req = 4'h0;
    model_reset();
    chk("midrst_busy", busy, 0);
    chk("midrst_j", j_out, 0);
    chk("midrst_gnt", gnt, 0);
    chk("midrst_cnt", cmd_cnt, 0);
    @(posedge clk); #1;
    chk("midrst_gnt2", gnt, 0);
    chk("midrst_busy2", busy, 0);
    cmd(4'b0001, 8'b00, 12'd7);
    cmd(4'b0010, 8'b1100, 12'o70);
    repeat (254) cmd(4'($urandom_range(1, 15)), 8'($urandom), 12'($urandom));
    chk("cnt_wrap", cmd_cnt, 0);
    bad = 1'b1;
    cmd(4'b0001, 8'b10, 12'd0);
    chk("bad_err", err, 1);
    bad = 1'b0;
    repeat (3) cmd(4'($urandom_range(1, 15)), 8'($urandom), 12'($urandom));
    chk("err_sticky", err, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
